flash_responder: RTL and testbench
==================================

# flash_responder

Synthesizable read-only Avalon-MM responder that models the flash core's `flash_mem_*` interface for the audio playback path. It stores sample words preloaded through a side port and answers `flash_mem_read` requests with programmable waitrequest stall and pipelined `flash_mem_readdatavalid` latency. The playback controller and its testbench can then exercise the flash handshake cycle-accurately without the vendor flash IP.

## Interface
Parameters:
- `MEM_AW`, 8: word-address bits of internal store (2^MEM_AW 32-bit words)
- `WAIT_CYCLES`, 2: stall cycles before a read is accepted (legal 0..15)
- `READ_LATENCY`, 3: cycles from accept edge to readdatavalid (legal 1..8)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `flash_mem_read` in 1: read request from initiator
- `flash_mem_address` in 23: word address; only bits [MEM_AW-1:0] used
- `flash_mem_byteenable` in 4: byte lanes to return; disabled lanes read as 0
- `flash_mem_waitrequest` out 1: high = request not accepted this cycle
- `flash_mem_readdata` out 32: read data, valid only with readdatavalid
- `flash_mem_readdatavalid` out 1: one-cycle pulse per accepted read
- `load_en` in 1: write strobe for preload port
- `load_addr` in MEM_AW: preload word address
- `load_data` in 32: preload data
- `read_count` out 16: accepted reads since reset, wraps 0xFFFF->0
- `protocol_err` out 1: sticky; initiator dropped read while stalled

## Operation
- FSM states: IDLE, STALL, ACCEPT. `flash_mem_waitrequest` = 1 in all states except ACCEPT (decoded from state, no combinational path from inputs).
- IDLE: read=1 -> STALL with counter=WAIT_CYCLES-1 (or -> ACCEPT directly if WAIT_CYCLES=0); else stay.
- STALL: read=0 -> set protocol_err, -> IDLE. Counter=0 -> ACCEPT; else decrement.
- ACCEPT: read=1 -> accept (capture masked word, push into pipeline, read_count+1), -> IDLE. read=0 -> set protocol_err, -> IDLE, no accept.
- Captured word: mem[address[MEM_AW-1:0]] with byte lane i zeroed if byteenable[i]=0. Upper address bits ignored (aliasing).
- Response pipeline: READ_LATENCY-stage shift register of {valid, data}; stage 0 loaded at accept edge, last stage drives outputs. Multiple reads may be in flight when READ_LATENCY > WAIT_CYCLES+2; order preserved.
- readdata holds last valid value when readdatavalid=0.
- Preload: load_en writes mem[load_addr] at the edge. Same-edge accept of the same address returns the OLD word. Load is allowed in any state.
- Memory contents are not cleared by reset.

## Timing
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, read_count=0, protocol_err=0, state=IDLE, all pipeline valids=0.
- Read first sampled high at edge E0 in IDLE: waitrequest low during cycle after edge E0+WAIT_CYCLES (WAIT_CYCLES=0: cycle after E0). Accept edge EA = E0+WAIT_CYCLES+1.
- readdatavalid high for exactly the cycle after edge EA+READ_LATENCY-1, i.e. READ_LATENCY cycles after accept.
- Back-to-back: read held high continuously gives one accept per WAIT_CYCLES+2 cycles (IDLE re-entered for one cycle between accepts).
- Reset mid-operation: in-flight responses dropped (no readdatavalid), FSM to IDLE, counters cleared next edge.
- read_count and protocol_err update on the accept/error edge.

## Test plan
- Preload mem[5]=0xDEADBEEF; defaults; read addr 5, BE=0xF held high -> waitrequest low 3rd cycle, readdatavalid 3 cycles after accept with 0xDEADBEEF, read_count=1.
- BE=0x5 on same word -> readdata 0x00AD00EF; address 0x000105 (MEM_AW=8) -> aliases to word 5.
- WAIT_CYCLES=0, READ_LATENCY=4, read held high over words 0..3 preloaded 0x10..0x13 -> accepts every 2 cycles, four ordered valid pulses 0x10..0x13, two responses overlap in pipeline.
- Drop read during STALL -> protocol_err=1 sticky, no readdatavalid, read_count unchanged; next read succeeds normally.
- load_en to word 7 (0x1111->0x2222) on same edge as accept of word 7 -> returns 0x1111; next read returns 0x2222.
- Assert reset one cycle after accept -> no readdatavalid ever appears, waitrequest=1, read_count=0, preloaded memory still readable after release.

Source files
------------

// File: rtl/flash_responder.sv
// flash_responder: read-only Avalon-MM responder standing in for the flash
// core's flash_mem_* port. Sample words are preloaded through a side port;
// reads are stalled by WAIT_CYCLES and answered READ_LATENCY cycles after
// acceptance through an in-order response pipeline.
module flash_responder #(
  parameter int MEM_AW       = 8,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_mem_read,
  input  logic [22:0]       flash_mem_address,
  input  logic [3:0]        flash_mem_byteenable,
  output logic              flash_mem_waitrequest,
  output logic [31:0]       flash_mem_readdata,
  output logic              flash_mem_readdatavalid,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [15:0]       read_count,
  output logic              protocol_err
);

  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        accept_fire;
  logic [31:0] masked_word;

  logic [31:0] mem [2**MEM_AW];

  logic [READ_LATENCY-1:0] pipe_v;
  logic [31:0]             pipe_d [READ_LATENCY];

  // Upper address bits alias onto the store; fold them so they are consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^flash_mem_address[22:MEM_AW];

  // A read completes on the edge that sees it high while waitrequest is low.
  assign accept_fire = (state == ACCEPT) && flash_mem_read;

  // Word at the request address with disabled byte lanes forced to zero.
  always_comb begin
    // NOTE: assign the full default first so every path drives masked_word
    // and no latch is inferred.
    masked_word = mem[flash_mem_address[MEM_AW-1:0]];
    for (int i = 0; i < 4; i++) begin
      if (!flash_mem_byteenable[i]) masked_word[8*i +: 8] = 8'h00;
    end
  end

  // Preload write port; a same-edge accept reads the pre-write word.
  always_ff @(posedge clk) begin
    // NOTE: the store is deliberately left out of reset so preloaded samples
    // survive a reset and the array maps onto plain RAM.
    if (load_en) mem[load_addr] <= load_data;
  end

  // Handshake FSM: stall, accept, then one IDLE cycle; waitrequest registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state                 <= IDLE;
      wait_cnt              <= 4'd0;
      flash_mem_waitrequest <= 1'b1;
      read_count            <= 16'd0;
      protocol_err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flash_mem_read) begin
            if (WAIT_CYCLES == 0) begin
              state                 <= ACCEPT;
              flash_mem_waitrequest <= 1'b0;
            end else begin
              state                 <= STALL;
              wait_cnt              <= 4'(WAIT_CYCLES - 1);
              flash_mem_waitrequest <= 1'b1;
            end
          end
        end
        STALL: begin
          if (!flash_mem_read) begin
            protocol_err          <= 1'b1;
            state                 <= IDLE;
            flash_mem_waitrequest <= 1'b1;
          end else if (wait_cnt == 4'd0) begin
            state                 <= ACCEPT;
            flash_mem_waitrequest <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACCEPT: begin
          state                 <= IDLE;
          flash_mem_waitrequest <= 1'b1;
          if (flash_mem_read) read_count   <= read_count + 16'd1;
          else                protocol_err <= 1'b1;
        end
        default: begin
          state                 <= IDLE;
          flash_mem_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  // Response pipeline: data only advances behind a valid, so the last stage
  // holds the most recent response while readdatavalid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= 32'd0;
    end else begin
      pipe_v[0] <= accept_fire;
      if (accept_fire) pipe_d[0] <= masked_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign flash_mem_readdatavalid = pipe_v[READ_LATENCY-1];
  assign flash_mem_readdata      = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_flash_responder.sv
// Bench for flash_responder: instance 0 uses default timing (wait 2, latency 3),
// instance 1 uses wait 0, latency 4. A request/response model checks all
// outputs of both instances every cycle; directed tests pin literal values.
module tb_flash_responder;

  logic        clk;
  logic        reset;
  logic        rd      [2];
  logic [22:0] addr    [2];
  logic [3:0]  be      [2];
  logic        ld_en   [2];
  logic [7:0]  ld_addr [2];
  logic [31:0] ld_data [2];
  logic        wr      [2];
  logic [31:0] rdata   [2];
  logic        rv      [2];
  logic [15:0] rcnt    [2];
  logic        perr    [2];

  int errors = 0;
  int checks = 0;

  flash_responder #(.MEM_AW(8), .WAIT_CYCLES(2), .READ_LATENCY(3)) dut0 (
    .clk(clk), .reset(reset),
    .flash_mem_read(rd[0]), .flash_mem_address(addr[0]),
    .flash_mem_byteenable(be[0]), .flash_mem_waitrequest(wr[0]),
    .flash_mem_readdata(rdata[0]), .flash_mem_readdatavalid(rv[0]),
    .load_en(ld_en[0]), .load_addr(ld_addr[0]), .load_data(ld_data[0]),
    .read_count(rcnt[0]), .protocol_err(perr[0])
  );

  flash_responder #(.MEM_AW(8), .WAIT_CYCLES(0), .READ_LATENCY(4)) dut1 (
    .clk(clk), .reset(reset),
    .flash_mem_read(rd[1]), .flash_mem_address(addr[1]),
    .flash_mem_byteenable(be[1]), .flash_mem_waitrequest(wr[1]),
    .flash_mem_readdata(rdata[1]), .flash_mem_readdatavalid(rv[1]),
    .load_en(ld_en[1]), .load_addr(ld_addr[1]), .load_data(ld_data[1]),
    .read_count(rcnt[1]), .protocol_err(perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  // ---------------- behavioural model ----------------
  // A request starts on the first edge read is seen high; it is accepted on
  // the (wait+2)-th consecutive edge of read high, and the response appears
  // after the edge (latency-1) edges later. Dropping read early is an error.
  typedef struct {
    int          inst;
    longint      due;
    logic [31:0] d;
  } resp_t;

  resp_t       rq [$];
  bit          pend  [2];
  int          seen  [2];
  logic [15:0] m_cnt [2];
  logic        m_err [2];
  logic        m_wr  [2];
  logic        m_v   [2];
  logic [31:0] m_d   [2];
  logic [31:0] mmem  [2][256];
  longint      cyc = 0;
  bit          chk_en = 0;

  int          v0_pulses = 0;
  logic [31:0] got1 [$];
  longint      got1_cyc [$];
  int          max_inflight1 = 0;

  task automatic step(input int k, input logic rst, input logic r, input logic [22:0] a,
                      input logic [3:0] b, input logic le, input logic [7:0] la,
                      input logic [31:0] ldd);
    bit          acc;
    logic [31:0] w;
    int          idx;
    resp_t       keep [$];
    acc = 0;
    w = mmem[k][a[7:0]];
    for (int i = 0; i < 4; i++) if (!b[i]) w[8*i +: 8] = 8'h00;
    if (rst) begin
      pend[k]  = 0;
      seen[k]  = 0;
      m_cnt[k] = 16'd0;
      m_err[k] = 1'b0;
      m_wr[k]  = 1'b1;
      m_v[k]   = 1'b0;
      m_d[k]   = 32'd0;
      foreach (rq[j]) if (rq[j].inst != k) keep.push_back(rq[j]);
      rq = keep;
    end else begin
      if (pend[k]) begin
        seen[k]++;
        if (!r) begin
          m_err[k] = 1'b1;
          pend[k]  = 0;
        end else if (seen[k] == wait_of(k) + 2) begin
          acc     = 1;
          pend[k] = 0;
        end
      end else if (r) begin
        pend[k] = 1;
        seen[k] = 1;
      end
      if (acc) begin
        rq.push_back('{inst: k, due: cyc + lat_of(k) - 1, d: w});
        m_cnt[k] = m_cnt[k] + 16'd1;
      end
      m_wr[k] = !(pend[k] && seen[k] == wait_of(k) + 1);
      m_v[k]  = 1'b0;
      idx = -1;
      foreach (rq[j]) if (idx < 0 && rq[j].inst == k) idx = j;
      if (idx >= 0 && rq[idx].due == cyc) begin
        m_v[k] = 1'b1;
        m_d[k] = rq[idx].d;
        rq.delete(idx);
      end
    end
    if (le) mmem[k][la] = ldd;
  endtask

  // Single compare process: advance the model on each edge, check 1 ns later.
  always begin
    @(posedge clk);
    cyc++;
    if (reset) chk_en = 1;
    for (int k = 0; k < 2; k++)
      step(k, reset, rd[k], addr[k], be[k], ld_en[k], ld_addr[k], ld_data[k]);
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("waitrequest%0d", k), {31'd0, wr[k]}, {31'd0, m_wr[k]});
        check($sformatf("readdatavalid%0d", k), {31'd0, rv[k]}, {31'd0, m_v[k]});
        check($sformatf("readdata%0d", k), rdata[k], m_d[k]);
        check($sformatf("read_count%0d", k), {16'd0, rcnt[k]}, {16'd0, m_cnt[k]});
        check($sformatf("protocol_err%0d", k), {31'd0, perr[k]}, {31'd0, m_err[k]});
      end
      if (rv[0] === 1'b1) v0_pulses++;
      if (rv[1] === 1'b1) begin
        got1.push_back(rdata[1]);
        got1_cyc.push_back(cyc);
      end
      if (!reset && (int'(rcnt[1]) - got1.size()) > max_inflight1)
        max_inflight1 = int'(rcnt[1]) - got1.size();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int k, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    @(negedge clk);
    ld_en[k] = 1'b0;
  endtask

  // Hold read until accepted; optionally load the same word on the accept edge.
  // Returns at the negedge just after the accept edge.
  task automatic do_read(input int k, input logic [22:0] a, input logic [3:0] b,
                         input bit same_load, input logic [31:0] ldd, output int waits);
    bit got_low;
    got_low = 0;
    @(negedge clk);
    rd[k] = 1'b1; addr[k] = a; be[k] = b; waits = 0;
    for (int n = 0; n < 40 && !got_low; n++) begin
      @(negedge clk);
      waits++;
      if (wr[k] === 1'b0) got_low = 1;
    end
    if (!got_low) check("accept_timeout", {31'd0, wr[k]}, 32'd0);
    if (same_load) begin
      ld_en[k] = 1'b1; ld_addr[k] = a[7:0]; ld_data[k] = ldd;
    end
    @(negedge clk);
    rd[k] = 1'b0; ld_en[k] = 1'b0;
  endtask

  // Count negedges (starting at 1 for the current one) until readdatavalid.
  task automatic wait_valid(input int k, output logic [31:0] d, output int lat);
    bit found;
    found = 0; lat = 0; d = 32'hxxxxxxxx;
    for (int n = 0; n < 40 && !found; n++) begin
      lat++;
      if (rv[k] === 1'b1) begin
        found = 1;
        d = rdata[k];
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("valid_timeout", {31'd0, rv[k]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int          waits, lat, base;
    logic [31:0] d;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 0; addr[k] = '0; be[k] = 4'hF; ld_en[k] = 0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_waitrequest", {31'd0, wr[0]}, 32'd1);
    check("rst_valid", {31'd0, rv[0]}, 32'd0);
    check("rst_readdata", rdata[0], 32'd0);
    check("rst_read_count", {16'd0, rcnt[0]}, 32'd0);
    check("rst_protocol_err", {31'd0, perr[0]}, 32'd0);
    reset = 1'b0;

    // Basic read with default timing.
    load(0, 8'd5, 32'hDEADBEEF);
    do_read(0, 23'd5, 4'hF, 0, 32'd0, waits);
    check("t1_wait_cycles", waits, 32'd3);
    wait_valid(0, d, lat);
    check("t1_data", d, 32'hDEADBEEF);
    check("t1_latency", lat, 32'd3);
    check("t1_read_count", {16'd0, rcnt[0]}, 32'd1);

    // Byte-lane masking and address aliasing.
    do_read(0, 23'd5, 4'h5, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t2_masked", d, 32'h00AD00EF);
    do_read(0, 23'h000105, 4'hF, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t2_alias", d, 32'hDEADBEEF);
    check("t2_read_count", {16'd0, rcnt[0]}, 32'd3);

    // Back-to-back reads, wait 0 / latency 4, overlapping responses.
    for (int i = 0; i < 4; i++) load(1, 8'(i), 32'h10 + i);
    begin
      int idx;
      idx = 0;
      @(negedge clk);
      rd[1] = 1'b1; addr[1] = 23'd0; be[1] = 4'hF;
      for (int n = 0; n < 60 && idx < 4; n++) begin
        @(negedge clk);
        if (wr[1] === 1'b0) begin
          @(negedge clk);
          idx++;
          if (idx == 4) rd[1] = 1'b0;
          else          addr[1] = 23'(idx);
        end
      end
      check("t3_accepts", idx, 32'd4);
    end
    repeat (8) @(negedge clk);
    check("t3_resp_count", got1.size(), 32'd4);
    if (got1.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3_data%0d", i), got1[i], 32'h10 + i);
        if (i > 0) check($sformatf("t3_spacing%0d", i), 32'(got1_cyc[i] - got1_cyc[i-1]), 32'd2);
      end
    end
    check("t3_inflight", max_inflight1, 32'd2);

    // Drop read while stalled.
    base = v0_pulses;
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 23'd5; be[0] = 4'hF;
    repeat (2) @(negedge clk);
    rd[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_protocol_err", {31'd0, perr[0]}, 32'd1);
    check("t4_read_count", {16'd0, rcnt[0]}, 32'd3);
    check("t4_no_valid", v0_pulses - base, 32'd0);
    do_read(0, 23'd5, 4'hF, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t4_recover_data", d, 32'hDEADBEEF);
    check("t4_recover_count", {16'd0, rcnt[0]}, 32'd4);
    check("t4_err_sticky", {31'd0, perr[0]}, 32'd1);

    // Load on the same edge as the accept of the same word.
    load(0, 8'd7, 32'h1111);
    do_read(0, 23'd7, 4'hF, 1, 32'h2222, waits);
    wait_valid(0, d, lat);
    check("t5_old_word", d, 32'h1111);
    do_read(0, 23'd7, 4'hF, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t5_new_word", d, 32'h2222);
    check("t5_read_count", {16'd0, rcnt[0]}, 32'd6);

    // Reset one cycle after accept drops the in-flight response.
    do_read(0, 23'd5, 4'hF, 0, 32'd0, waits);
    base = v0_pulses;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_valid", v0_pulses - base, 32'd0);
    check("t6_waitrequest", {31'd0, wr[0]}, 32'd1);
    check("t6_read_count", {16'd0, rcnt[0]}, 32'd0);
    check("t6_protocol_err", {31'd0, perr[0]}, 32'd0);
    do_read(0, 23'd5, 4'hF, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t6_mem_kept5", d, 32'hDEADBEEF);
    do_read(0, 23'd7, 4'hF, 0, 32'd0, waits);
    wait_valid(0, d, lat);
    check("t6_mem_kept7", d, 32'h2222);
    check("t6_read_count_after", {16'd0, rcnt[0]}, 32'd2);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
